// File: rtl/voice_phase_scanner_pkg.sv
// Shared definitions for the voice table: scanner states and record field layout.
// A record is {active, increment, phase}; the note handler builds records with the same helpers.
package voice_phase_scanner_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WB   = 2'd2
  } scan_state_t;

  localparam int PHASE_LSB = 0;

  function automatic int recWidth(input int phaseW);
    return 2 * phaseW + 1;
  endfunction

  function automatic int activeBit(input int phaseW);
    return 2 * phaseW;
  endfunction

  function automatic int incLsb(input int phaseW);
    return phaseW;
  endfunction

endpackage

// File: rtl/dptrueram.sv
// True-dual-port, read-first, single-clock RAM holding the voice table.
// Port A belongs to the note handler, port B to the phase scanner.
module dptrueram #(
  parameter int addr_width = 4,
  parameter int data_width = 49
) (
  input  logic                  clk,
  input  logic [addr_width-1:0] addra,
  input  logic                  wea,
  input  logic [data_width-1:0] dina,
  output logic [data_width-1:0] douta,
  input  logic [addr_width-1:0] addrb,
  input  logic                  web,
  input  logic [data_width-1:0] dinb,
  output logic [data_width-1:0] doutb
);

  logic [data_width-1:0] r_mem [0:(2**addr_width)-1];

  // Registered reads see the old contents (read-first); both ports may write, B wins on a clash.
  always_ff @(posedge clk) begin
    douta <= r_mem[addra];
    doutb <= r_mem[addrb];
    if (wea) r_mem[addra] <= dina;
    if (web) r_mem[addrb] <= dinb;
  end

endmodule

// File: rtl/voice_phase_scanner.sv
// Port-B master of the voice table: on each sample tick it walks every voice record,
// advances the phase of active voices by their increment and streams the results out.
module voice_phase_scanner
  import voice_phase_scanner_pkg::*;
#(
  parameter int VOICE_BITS = 4,
  parameter int PHASE_W    = 24,
  localparam int REC_W     = recWidth(PHASE_W)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_tick,
  output logic [VOICE_BITS-1:0] ram_addr,
  output logic                  ram_we,
  output logic [REC_W-1:0]      ram_din,
  input  logic [REC_W-1:0]      ram_dout,
  output logic                  voice_valid,
  output logic [VOICE_BITS-1:0] voice_idx,
  output logic [PHASE_W-1:0]    voice_phase,
  output logic                  voice_active,
  output logic                  voice_wrap,
  output logic                  scan_done,
  output logic                  busy,
  output logic                  overrun
);

  localparam int ACT_BIT = activeBit(PHASE_W);
  localparam int INC_LSB = incLsb(PHASE_W);
  localparam logic [VOICE_BITS-1:0] LAST_V = VOICE_BITS'((2**VOICE_BITS) - 1);

  scan_state_t r_state;
  scan_state_t w_nextState;
  logic [VOICE_BITS-1:0] r_v;
  logic [VOICE_BITS-1:0] w_nextV;

  logic [VOICE_BITS-1:0] w_ramAddr;
  logic                  w_ramWe;
  logic [REC_W-1:0]      w_ramDin;

  logic                  w_active;
  logic [PHASE_W-1:0]    w_inc;
  logic [PHASE_W-1:0]    w_phase;
  logic [PHASE_W:0]      w_sum;
  logic                  w_busy;

  logic                  r_valid;
  logic [VOICE_BITS-1:0] r_idx;
  logic [PHASE_W-1:0]    r_phase;
  logic                  r_active;
  logic                  r_wrap;
  logic                  r_done;
  logic                  r_overrun;

  assign w_active = ram_dout[ACT_BIT];
  assign w_inc    = ram_dout[INC_LSB +: PHASE_W];
  assign w_phase  = ram_dout[PHASE_LSB +: PHASE_W];
  assign w_sum    = {1'b0, w_phase} + {1'b0, w_inc};
  assign w_busy   = (r_state != ST_IDLE);

  // Sweep sequencing and port-B drive: read a record, then write its advanced phase back.
  always_comb begin
    w_nextState = r_state;
    w_nextV     = r_v;
    w_ramAddr   = '0;
    w_ramWe     = 1'b0;
    w_ramDin    = '0;
    case (r_state)
      ST_IDLE: begin
        if (sample_tick) begin
          w_nextState = ST_RD;
          w_nextV     = '0;
        end
      end
      ST_RD: begin
        w_ramAddr   = r_v;
        w_nextState = ST_WB;
      end
      ST_WB: begin
        w_ramAddr = r_v;
        if (w_active) begin
          w_ramWe  = 1'b1;
          w_ramDin = {1'b1, w_inc, w_sum[PHASE_W-1:0]};
        end
        if (r_v == LAST_V) begin
          w_nextState = ST_IDLE;
        end else begin
          w_nextV     = r_v + 1'b1;
          w_nextState = ST_RD;
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // State and voice-counter registers; reset abandons any sweep in progress.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_v     <= '0;
    end else begin
      r_state <= w_nextState;
      r_v     <= w_nextV;
    end
  end

  // Output stream register: one strobe per voice, issued the cycle after its write-back.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_idx     <= '0;
      r_phase   <= '0;
      r_active  <= 1'b0;
      r_wrap    <= 1'b0;
      r_done    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_valid   <= (r_state == ST_WB);
      r_done    <= (r_state == ST_WB) && (r_v == LAST_V);
      r_overrun <= sample_tick && w_busy;
      if (r_state == ST_WB) begin
        r_idx    <= r_v;
        r_active <= w_active;
        r_phase  <= w_active ? w_sum[PHASE_W-1:0] : w_phase;
        r_wrap   <= w_active & w_sum[PHASE_W];
      end
    end
  end

  assign ram_addr     = w_ramAddr;
  assign ram_we       = w_ramWe;
  assign ram_din      = w_ramDin;
  assign voice_valid  = r_valid;
  assign voice_idx    = r_idx;
  assign voice_phase  = r_phase;
  assign voice_active = r_active;
  assign voice_wrap   = r_wrap;
  assign scan_done    = r_done;
  assign busy         = w_busy;
  assign overrun      = r_overrun;

endmodule

// File: tb/tb_voice_phase_scanner.sv
// Bench for voice_phase_scanner with the voice-table RAM on port B; port A loads and inspects records.
module tb_voice_phase_scanner;

  localparam int VB = 4;
  localparam int PW = 24;
  localparam int RW = 2 * PW + 1;
  localparam int NV = 16;

  typedef struct {
    logic [VB-1:0] idx;
    logic [PW-1:0] phase;
    logic          active;
    logic          wrap;
    logic          done;
    int            cycle;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          sample_tick;
  logic [VB-1:0] ram_addr;
  logic          ram_we;
  logic [RW-1:0] ram_din;
  logic [RW-1:0] ram_dout;
  logic          voice_valid;
  logic [VB-1:0] voice_idx;
  logic [PW-1:0] voice_phase;
  logic          voice_active;
  logic          voice_wrap;
  logic          scan_done;
  logic          busy;
  logic          overrun;

  logic [VB-1:0] addra;
  logic          wea;
  logic [RW-1:0] dina;
  logic [RW-1:0] douta;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int overrunCount = 0;
  int weAt7Count = 0;
  exp_t sbQ[$];
  exp_t monE;
  logic [RW-1:0] model [0:NV-1];

  voice_phase_scanner #(.VOICE_BITS(VB), .PHASE_W(PW)) dut (
    .clk(clk), .reset_n(reset_n), .sample_tick(sample_tick),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
    .voice_valid(voice_valid), .voice_idx(voice_idx), .voice_phase(voice_phase),
    .voice_active(voice_active), .voice_wrap(voice_wrap), .scan_done(scan_done),
    .busy(busy), .overrun(overrun)
  );

  dptrueram #(.addr_width(VB), .data_width(RW)) ram (
    .clk(clk),
    .addra(addra), .wea(wea), .dina(dina), .douta(douta),
    .addrb(ram_addr), .web(ram_we), .dinb(ram_din), .doutb(ram_dout)
  );

  always #5 clk = ~clk;

  // Cycle counter used to place expected strobes in time.
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and tallies side-band events.
  always @(negedge clk) begin
    if (overrun === 1'b1) overrunCount++;
    if (ram_we === 1'b1 && ram_addr == 4'd7) weAt7Count++;
    if (voice_valid === 1'b1) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpectedStrobe actual idx=%0d expected no strobe", voice_idx);
      end else begin
        monE = sbQ.pop_front();
        checkOutput("strobeIdx", 64'(voice_idx), 64'(monE.idx));
        checkOutput("strobePhase", 64'(voice_phase), 64'(monE.phase));
        checkOutput("strobeActive", 64'(voice_active), 64'(monE.active));
        checkOutput("strobeWrap", 64'(voice_wrap), 64'(monE.wrap));
        checkOutput("strobeDone", 64'(scan_done), 64'(monE.done));
        checkOutput("strobeCycle", 64'(cycleCnt), 64'(monE.cycle));
      end
    end else if (scan_done === 1'b1) begin
      checks++;
      errors++;
      $display("[TB] FAIL strayScanDone actual=1 expected=0");
    end
  end

  // Issues one tick (called at a negedge); queues the first `strobes` expected outputs
  // and applies the first `updates` voice updates to the model.
  task automatic applyStimulus(input int strobes, input int updates);
    logic [RW-1:0] rec;
    logic [RW-1:0] newRec;
    logic [PW:0]   s;
    exp_t e;
    sample_tick = 1'b1;
    for (int v = 0; v < NV; v++) begin
      rec = model[v];
      s = {1'b0, rec[PW-1:0]} + {1'b0, rec[2*PW-1:PW]};
      e.idx = 4'(v);
      e.active = rec[RW-1];
      if (rec[RW-1]) begin
        e.phase = s[PW-1:0];
        e.wrap = s[PW];
        newRec = {1'b1, rec[2*PW-1:PW], s[PW-1:0]};
      end else begin
        e.phase = rec[PW-1:0];
        e.wrap = 1'b0;
        newRec = rec;
      end
      e.done = (v == NV - 1);
      e.cycle = cycleCnt + 3 + 2 * v;
      if (v < strobes) sbQ.push_back(e);
      if (v < updates) model[v] = newRec;
    end
    @(negedge clk);
    sample_tick = 1'b0;
  endtask

  task automatic loadVoice(input int idx, input logic [RW-1:0] rec);
    addra = 4'(idx);
    dina = rec;
    wea = 1'b1;
    model[idx] = rec;
    @(negedge clk);
    wea = 1'b0;
  endtask

  task automatic readVoice(input int idx, output logic [RW-1:0] rec);
    addra = 4'(idx);
    @(negedge clk);
    rec = douta;
  endtask

  task automatic waitSweepDone(input int budget);
    bit ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy === 1'b0 && sbQ.size() == 0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("[TB] FAIL sweepTimeout actual busy=%0b pending=%0d expected idle", busy, sbQ.size());
    end
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_valid"}, 64'(voice_valid), 64'd0);
    checkOutput({tag, "_idx"}, 64'(voice_idx), 64'd0);
    checkOutput({tag, "_phase"}, 64'(voice_phase), 64'd0);
    checkOutput({tag, "_active"}, 64'(voice_active), 64'd0);
    checkOutput({tag, "_wrap"}, 64'(voice_wrap), 64'd0);
    checkOutput({tag, "_done"}, 64'(scan_done), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
    checkOutput({tag, "_overrun"}, 64'(overrun), 64'd0);
    checkOutput({tag, "_ramAddr"}, 64'(ram_addr), 64'd0);
    checkOutput({tag, "_ramWe"}, 64'(ram_we), 64'd0);
    checkOutput({tag, "_ramDin"}, 64'(ram_din), 64'd0);
  endtask

  // Watchdog so the run always ends.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence.
  initial begin
    logic [RW-1:0] rec;
    int ovSnap;
    reset_n = 1'b0;
    sample_tick = 1'b0;
    addra = '0;
    wea = 1'b0;
    dina = '0;
    repeat (3) @(negedge clk);
    checkIdleOutputs("reset");
    reset_n = 1'b1;

    for (int v = 0; v < NV; v++) loadVoice(v, '0);
    loadVoice(3, {1'b1, 24'h000100, 24'h000000});
    loadVoice(5, {1'b1, 24'h000010, 24'hFFFFF8});
    loadVoice(7, {1'b0, 24'h000000, 24'h123456});

    // First sweep: plain advance, wrap-around, inactive voice.
    applyStimulus(NV, NV);
    checkOutput("busyAfterTick", 64'(busy), 64'd1);
    waitSweepDone(100);
    checkOutput("noWriteAddr7", 64'(weAt7Count), 64'd0);
    readVoice(3, rec);
    checkOutput("ram3AfterSweep1", 64'(rec), 64'({1'b1, 24'h000100, 24'h000100}));
    readVoice(5, rec);
    checkOutput("ram5Wrapped", 64'(rec), 64'({1'b1, 24'h000010, 24'h000008}));
    readVoice(7, rec);
    checkOutput("ram7Untouched", 64'(rec), 64'({1'b0, 24'h000000, 24'h123456}));

    // Tick while busy is dropped and reported once.
    ovSnap = overrunCount;
    applyStimulus(NV, NV);
    repeat (3) @(negedge clk);
    applyStimulus(0, 0);
    checkOutput("overrunPulse", 64'(overrun), 64'd1);
    waitSweepDone(100);
    checkOutput("overrunCountMidSweep", 64'(overrunCount - ovSnap), 64'd1);
    readVoice(3, rec);
    checkOutput("ram3AdvancedOnce", 64'(rec), 64'({1'b1, 24'h000100, 24'h000200}));

    // Reset during write-back of voice 9.
    loadVoice(9, {1'b1, 24'h000020, 24'h000100});
    loadVoice(12, {1'b1, 24'h000040, 24'h000005});
    applyStimulus(9, 10);
    repeat (19) @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    checkIdleOutputs("midReset");
    reset_n = 1'b1;
    checkOutput("queueAfterReset", 64'(sbQ.size()), 64'd0);
    readVoice(9, rec);
    checkOutput("ram9WriteLanded", 64'(rec), 64'({1'b1, 24'h000020, 24'h000120}));
    readVoice(12, rec);
    checkOutput("ram12Unchanged", 64'(rec), 64'({1'b1, 24'h000040, 24'h000005}));
    for (int v = 10; v < NV; v++) begin
      readVoice(v, rec);
      checkOutput("ramTailVsModel", 64'(rec), 64'(model[v]));
    end
    applyStimulus(NV, NV);
    waitSweepDone(100);
    readVoice(3, rec);
    checkOutput("ram3AfterReset", 64'(rec), 64'({1'b1, 24'h000100, 24'h000400}));

    // Ten sweeps at the tightest legal spacing.
    ovSnap = overrunCount;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(NV, NV);
      if (k < 9) repeat (2 * NV) @(negedge clk);
    end
    waitSweepDone(100);
    checkOutput("noOverrunBackToBack", 64'(overrunCount - ovSnap), 64'd0);
    readVoice(3, rec);
    checkOutput("ram3After10Sweeps", 64'(rec), 64'({1'b1, 24'h000100, 24'h000E00}));
    for (int v = 0; v < NV; v++) begin
      readVoice(v, rec);
      checkOutput("ramVsModel", 64'(rec), 64'(model[v]));
    end

    // Tick coincident with the final write-back is dropped too.
    applyStimulus(NV, NV);
    repeat (2 * NV - 1) @(negedge clk);
    applyStimulus(0, 0);
    checkOutput("overrunFinalWb", 64'(overrun), 64'd1);
    checkOutput("idleAfterFinalWb", 64'(busy), 64'd0);
    waitSweepDone(100);
    readVoice(3, rec);
    checkOutput("ram3FinalSweep", 64'(rec), 64'({1'b1, 24'h000100, 24'h000F00}));

    repeat (4) @(negedge clk);
    checkOutput("queueDrained", 64'(sbQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
